// File: rtl/ssd_digit_driver_if.sv
// Display-side signal bundle for the seven-segment digit driver.
// Latency: n/a (wiring only).
// Backpressure: none; the value is sampled continuously, outputs are free-running.
interface ssd_digit_driver_if;
  logic [12:0] value;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic [15:0] bcd;
  logic        busy;

  // Driver of the binary value / observer of the display.
  modport master (
    output value,
    input  anode,
    input  cathode,
    input  bcd,
    input  busy
  );

  // The digit driver itself.
  modport slave (
    input  value,
    output anode,
    output cathode,
    output bcd,
    output busy
  );
endinterface

// File: rtl/ssd_digit_driver.sv
// Binary-to-BCD (double-dabble) converter plus 4-digit multiplexed seven-segment driver.
// Latency: 15 clocks per conversion (1 capture, 13 shifts, 1 commit), reconverting continuously.
// Backpressure: none; value changes during a conversion are picked up at the next capture.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module ssd_digit_driver #(
  parameter int REFRESH_BITS = 18
) (
  input  logic               clk,
  input  logic               rst,
  ssd_digit_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [12:0]             shreg_q, shreg_d;
  logic [15:0]             scratch_q, scratch_d;
  logic [3:0]              iter_q, iter_d;
  logic [15:0]             bcd_q, bcd_d;
  logic                    busy_q, busy_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

  logic [15:0] scratch_adj;
  logic [28:0] shifted;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  seg;

  // Per-nibble add-3 correction, 4-bit wrap, no carry into the next nibble.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Active-low gfedcba pattern for one decimal digit; non-decimal codes blank.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    busy_d    = busy_q;
    refresh_d = refresh_q + 1'b1;

    scratch_adj = {add3(scratch_q[15:12]), add3(scratch_q[11:8]),
                   add3(scratch_q[7:4]),   add3(scratch_q[3:0])};
    shifted     = {scratch_adj, shreg_q} << 1;

    case (state_q)
      IDLE: begin
        shreg_d   = bus.value;
        scratch_d = 16'h0000;
        iter_d    = 4'd0;
        busy_d    = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        {scratch_d, shreg_d} = shifted;
        iter_d = iter_q + 4'd1;
        busy_d = 1'b1;
        if (iter_q == 4'd12) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        bcd_d   = scratch_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      refresh_q <= refresh_d;
    end
  end

  // Digit select and segment decode from the committed digits only.
  always_comb begin
    idx = refresh_q[REFRESH_BITS-1 -: 2];
    nib = bcd_q[{idx, 2'b00} +: 4];
    blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    case (idx)
      2'd3:    blank = (bcd_q[15:12] == 4'd0);
      2'd2:    blank = (bcd_q[15:8] == 8'd0);
      2'd1:    blank = (bcd_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    seg = blank ? 7'b1111111 : decode(nib);
  end

  assign bus.anode   = ~(4'b0001 << idx);
  assign bus.cathode = seg;
  assign bus.bcd     = bcd_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_ssd_digit_driver.sv
// Scoreboard bench for ssd_digit_driver: stimulus pushes expected BCD at capture,
// a monitor pops on each commit and checks display scan every cycle.
module tb_ssd_digit_driver;
  localparam int RB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ssd_digit_driver_if bus_if ();

  ssd_digit_driver #(.REFRESH_BITS(RB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  logic [15:0] exp_q[$];

  // Reference conversion: decimal digits by plain arithmetic.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] rand_val();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 13'd8191;
    if (r == 1) return 13'd0;
    if (r == 2) return 13'($urandom_range(0, 99));
    return 13'($urandom_range(0, 8191));
  endfunction

  // One negedge of stimulus: apply reset/value, then record what the next edge captures.
  task automatic step(input bit rnd, input bit setv, input logic [12:0] v, input bit r);
    @(negedge clk);
    rst = r;
    if (r) exp_q.delete();
    if (setv) bus_if.value = v;
    else if (rnd && bus_if.busy && $urandom_range(0, 7) == 0) bus_if.value = rand_val();
    if (!rst && !bus_if.busy) begin
      exp_q.push_back(to_bcd(int'(bus_if.value)));
      pushes++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 13'd0, 0);
  endtask

  task automatic wait_capture();
    int p0;
    int k;
    p0 = pushes;
    k = 0;
    while (pushes == p0 && k < 40) begin
      step(0, 0, 13'd0, 0);
      k++;
    end
    chk("capture_timeout", 32'(pushes != p0), 32'd1);
  endtask

  // Monitor: model of refresh counter and committed digits, checked each cycle.
  int          cnt_m = 0;
  int          run_len = 0;
  bit          prev_busy = 0;
  logic [15:0] committed = 16'h0;

  always @(posedge clk) begin
    int idx;
    int d;
    bit blank;
    logic [15:0] e;
    #1;
    if (rst) begin
      cnt_m = 0;
      run_len = 0;
      prev_busy = 0;
      committed = 16'h0;
      chk("rst_bcd", 32'(bus_if.bcd), 32'h0);
      chk("rst_busy", 32'(bus_if.busy), 32'h0);
      chk("rst_anode", 32'(bus_if.anode), 32'b1110);
      chk("rst_cathode", 32'(bus_if.cathode), 32'b1000000);
    end else begin
      cnt_m = (cnt_m + 1) % (1 << RB);
      if (bus_if.busy) run_len++;
      if (prev_busy && !bus_if.busy) begin
        chk("busy_len", 32'(run_len), 32'd14);
        if (exp_q.size() == 0) begin
          chk("commit_unexpected", 32'(bus_if.bcd), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("commit_bcd", 32'(bus_if.bcd), 32'(e));
          committed = e;
        end
        run_len = 0;
      end
      prev_busy = bus_if.busy;
      chk("bcd_stable", 32'(bus_if.bcd), 32'(committed));
      idx = (cnt_m >> (RB - 2)) & 3;
      d = int'((committed >> (4 * idx)) & 16'hF);
      blank = 0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (idx == 3) blank = (committed[15:12] == 0);
      if (idx == 2) blank = (committed[15:8] == 0);
      if (idx == 1) blank = (committed[15:4] == 0);
`endif
      chk("anode", 32'(bus_if.anode), 32'(4'(~(4'b0001 << idx))));
      chk("cathode", 32'(bus_if.cathode), 32'(blank ? 7'b1111111 : seg_of(d)));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.value = 13'd1234;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // Reset release with 1234 held.
    step(0, 1, 13'd1234, 0);
    run(20);
    // Boundary and small values.
    step(0, 1, 13'd8191, 0);
    run(32);
    step(0, 1, 13'd0, 0);
    run(32);
    step(0, 1, 13'd9, 0);
    run(32);
    step(0, 1, 13'd7, 0);
    run(40);
    // Value change in the middle of a conversion.
    step(0, 1, 13'd1234, 0);
    wait_capture();
    run(4);
    step(0, 1, 13'd4321, 0);
    run(35);
    // Reset during a conversion of 5555.
    step(0, 1, 13'd5555, 0);
    wait_capture();
    run(7);
    step(0, 0, 13'd0, 1);
    step(0, 0, 13'd0, 1);
    step(0, 0, 13'd0, 0);
    run(20);
    // Randomized values with mid-conversion changes.
    for (int i = 0; i < 3000; i++) step(1, 0, 13'd0, 0);
    @(posedge clk);
    #2;
    chk("queue_residue", 32'(exp_q.size() <= 1), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssd_digit_driver.md
# ssd_digit_driver

Seven-segment display driver sitting directly downstream of the CPU top-level debug mux: it consumes the 13-bit SSD value selected by `SSDSel` and drives a 4-digit common-anode display. The block converts the binary value to four BCD digits with a sequential shift-add-3 (double-dabble) engine and time-multiplexes the digits with a free-running refresh counter. Everything runs on a single clock domain.

## Interface
Parameters:
- `REFRESH_BITS`, default 18: width of the refresh counter. The top 2 bits select the active digit.

Ports:
- `clk`  input  1  system clock; all state is updated on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `value`  input  13  binary value to display (0–8191).
- `anode`  output  4  digit enables, active-low; bit 0 is the rightmost (ones) digit.
- `cathode`  output  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `bcd`  output  16  committed display digits `{thousands,hundreds,tens,ones}`.
- `busy`  output  1  high while a conversion is in progress (SHIFT or LOAD state).

## Operation
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE: capture `value` into a 13-bit shift register, clear the 16-bit BCD scratch register, set the iteration counter to 0, go to SHIFT.
  - SHIFT: each cycle, every scratch nibble ≥5 gets +3. Then `{scratch, shreg}` shifts left by 1. The iteration counter increments. After the 13th shift, go to LOAD.
  - LOAD: copy scratch to `bcd`, go to IDLE.
- A full cycle is 15 clocks. The block reconverts continuously with no start handshake.
- Changes on `value` during SHIFT or LOAD are ignored; the new value is captured at the next IDLE.
- The iteration counter is 4 bits and compares to 12 on the last shift. Add-3 is done per nibble, in 4 bits, with no carry between nibbles. Max input 8191 gives `bcd` = 16'h8191, so there is no overflow.
- Refresh counter:
  - `REFRESH_BITS` wide, free-running, wraps to 0.
  - Digit index `idx` = counter[MSB:MSB-1].
  - `anode` = ~(4'b0001 << idx).
  - The displayed nibble is `bcd[4*idx+3 : 4*idx]`.
- Cathode decode (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble values 10–15 cannot occur; decode them as blank 1111111.
- `anode` and `cathode` are combinational from the refresh counter and `bcd`. There is no glitch filtering.

## Timing
- Reset values:
  - FSM = IDLE, refresh counter = 0, shift/scratch/iteration registers = 0.
  - `bcd` = 16'h0000, `busy` = 0.
  - `anode` = 4'b1110, `cathode` = 1000000 (digit 0 showing "0").
- After `rst` falls:
  - Edge 1: IDLE captures `value`.
  - Edges 2–14: the 13 shifts.
  - Edge 15: LOAD commits. The new `bcd` is visible after edge 15.
- `busy` is registered: high after edges 1–14, low after edge 15 (the IDLE cycle).
- Reset asserted mid-conversion: immediate abort, all registers return to reset values, the partial result is discarded, and `bcd` reads 0.
- The committed `bcd` changes only at LOAD. The display never shows partial scratch data.
- Digit dwell is 2^(REFRESH_BITS-2) clocks. The full scan period is 2^REFRESH_BITS clocks.

## Configuration
- `SSD_LEADING_ZERO_BLANK_EN` defined:
  - Digit 3 is blanked when it is 0.
  - Digit 2 is blanked when digits 3 and 2 are both 0.
  - Digit 1 is blanked when digits 3..1 are all 0.
  - Digit 0 is never blanked.
  - Blanking forces `cathode` = 1111111 while that digit is selected. `anode` is unaffected.
- Not defined: all four digits are always shown, including leading zeros.

## Test plan
- Reset release with `value`=13'd1234 held: `busy` high for 14 cycles; `bcd`=16'h1234 after edge 15; `bcd`=0 before that.
- `value`=13'd8191: `bcd`=16'h8191. `value`=0: `bcd`=16'h0000. `value`=13'd9: `bcd`=16'h0009.
- `value` changes 1234→4321 at clock 5 of SHIFT: the first commit is 16'h1234; the next commit, 15 clocks later, is 16'h4321.
- `rst` pulsed at clock 8 of a conversion of 5555: `bcd`=0 and FSM=IDLE immediately; 16'h5555 commits 15 clocks after release.
- `REFRESH_BITS`=4, `bcd`=16'h1234:
  - `anode` sequence 1110,1101,1011,0111, each lasting 4 clocks.
  - `cathode` sequence 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
- `SSD_LEADING_ZERO_BLANK_EN` defined, `value`=7: `cathode`=1111111 for idx 3,2,1 and 1111000 for idx 0. Undefined: 1000000 for idx 3,2,1.
